// File: rtl/grid_renderer_pkg.sv
// Shared constants, colour codes and FSM encoding for the grid renderer
// and its scan counter.
package grid_renderer_pkg;

    localparam int GRID_W    = 160;
    localparam int GRID_H    = 120;
    localparam int GRID_BITS = GRID_W * GRID_H;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BULLET = 3'b111;
    localparam logic [2:0] COL_USER   = 3'b010;
    localparam logic [2:0] COL_ENEMY  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/scan_counter.sv
// Column-major pixel walker: cy runs fastest, cx steps when cy wraps.
// 'last' flags the final pixel so the owner can stop on the same edge.
module scan_counter
    import grid_renderer_pkg::*;
#(
    parameter int W = GRID_W,
    parameter int H = GRID_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    localparam logic [7:0] X_LAST = 8'(W - 1);
    localparam logic [6:0] Y_LAST = 7'(H - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx <= 8'd0;
            cy <= 7'd0;
        end else if (clear) begin
            cx <= 8'd0;
            cy <= 7'd0;
        end else if (enable) begin
            if (cy == Y_LAST) begin
                cy <= 7'd0;
                cx <= (cx == X_LAST) ? 8'd0 : cx + 8'd1;
            end else begin
                cy <= cy + 7'd1;
            end
        end
    end

    assign last = (cx == X_LAST) && (cy == Y_LAST);

endmodule

// File: rtl/grid_renderer.sv
// Walks the bullet grid once per start, emitting one VGA plot per cycle with
// the player ship and enemy overlaid, and reports enemy hits per frame.
module grid_renderer
    import grid_renderer_pkg::*;
#(
    parameter int WIDTH     = GRID_W,
    parameter int HEIGHT    = GRID_H,
    parameter int USER_ROW  = 0,
    parameter int ENEMY_ROW = 119
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   grid,
    input  logic [7:0]                user_x,
    input  logic [7:0]                enemy_x,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic [2:0]                colour,
    output logic                      plot,
    output logic                      busy,
    output logic                      done,
    output logic                      hit
);

    localparam logic [14:0] H15  = 15'(HEIGHT);
    localparam logic [6:0]  UROW = 7'(USER_ROW);
    localparam logic [6:0]  EROW = 7'(ENEMY_ROW);

    state_t      state, state_next;
    logic [7:0]  cx, ux, ex;
    logic [6:0]  cy;
    logic        last, clear, enable, acc;
    logic [14:0] idx;
    logic        bit_set, at_user, at_enemy;
    logic [2:0]  pix_col;

    scan_counter #(.W(WIDTH), .H(HEIGHT)) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    // Grid is read live, so bullets moving mid-frame show in unscanned pixels.
    assign idx      = H15 * {7'd0, cx} + {8'd0, cy};
    assign bit_set  = grid[idx];
    assign at_user  = (cx == ux) && (cy == UROW);
    assign at_enemy = (cx == ex) && (cy == EROW);

    always_comb begin
        pix_col = COL_BLACK;
        if (at_user)       pix_col = COL_USER;
        else if (at_enemy) pix_col = COL_ENEMY;
        else if (bit_set)  pix_col = COL_BULLET;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        enable     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SCAN;
                    clear      = 1'b1;
                end
            end
            ST_SCAN: begin
                enable = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= COL_BLACK;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hit    <= 1'b0;
            ux     <= 8'd0;
            ex     <= 8'd0;
            acc    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    plot <= 1'b0;
                    if (start) begin
                        ux   <= user_x;
                        ex   <= enemy_x;
                        acc  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    x      <= cx;
                    y      <= cy;
                    colour <= pix_col;
                    plot   <= 1'b1;
                    // Hit counts even though the enemy sprite hides the bullet.
                    if (at_enemy && bit_set) acc <= 1'b1;
                end
                ST_DONE: begin
                    plot <= 1'b0;
                    done <= 1'b1;
                    busy <= 1'b0;
                    hit  <= acc;
                end
                default: plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: frame capture against a pixel-level
// colour model built from the overlay priority rules.
module tb_grid_renderer;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [19199:0] grid;
    logic [7:0]     user_x, enemy_x;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot, busy, done, hit;

    grid_renderer dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .grid    (grid),
        .user_x  (user_x),
        .enemy_x (enemy_x),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done),
        .hit     (hit)
    );

    always #5 clock = ~clock;

    int checks = 0, passes = 0, fails = 0;

    logic [2:0] fb  [160][120];
    logic [2:0] efb [160][120];
    int   nplot, ndone, order_err, gap, extra_plot, busy_err;
    int   fx, fy, lx, ly;
    logic cap_hit, cap_busy, exp_hit;
    int   flip_at [2];
    int   flip_idx[2];
    int   mux, mex;

    function automatic logic [2:0] model_colour(int px, int py);
        if (px == mux && py == 0)   return 3'b010;
        if (px == mex && py == 119) return 3'b100;
        if (grid[120*px + py])      return 3'b111;
        return 3'b000;
    endfunction

    function automatic int count_pix_bad();
        int bad = 0;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                if (fb[i][j] !== efb[i][j]) bad++;
        return bad;
    endfunction

    // Records one frame of writes plus the model's expectation for each pixel
    // in scan order, and optionally perturbs inputs at given write counts.
    task automatic capture(input int p1, input int p2, input bit hold,
                           input int ux_at, input logic [7:0] ux_val);
        int ex_x = 0, ex_y = 0;
        bit seen = 0;
        nplot = 0; ndone = 0; order_err = 0; gap = 0; extra_plot = 0; busy_err = 0;
        exp_hit = 0; cap_hit = 0; cap_busy = 1; fx = -1; fy = -1; lx = -1; ly = -1;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) begin
                fb[i][j]  = 3'bxxx;
                efb[i][j] = 3'bxxx;
            end
        for (int c = 0; c < 20000; c++) begin
            @(negedge clock);
            if (plot) begin
                if (!seen) begin fx = int'(x); fy = int'(y); seen = 1; end
                lx = int'(x); ly = int'(y);
                if (int'(x) != ex_x || int'(y) != ex_y) order_err++;
                if (!busy) busy_err++;
                if (x < 160 && y < 120) fb[x][y] = colour;
                if (ex_x < 160) begin
                    efb[ex_x][ex_y] = model_colour(ex_x, ex_y);
                    if (ex_x == mex && ex_y == 119 && grid[120*ex_x + ex_y]) exp_hit = 1;
                end
                ex_y++;
                if (ex_y == 120) begin ex_y = 0; ex_x++; end
                nplot++;
            end else if (!seen && !done) gap++;
            if (done) begin
                ndone++; cap_hit = hit; cap_busy = busy;
                break;
            end
            start = hold || (nplot == p1) || (nplot == p2);
            if (nplot == ux_at) user_x = ux_val;
            for (int k = 0; k < 2; k++)
                if (nplot == flip_at[k]) grid[flip_idx[k]] = ~grid[flip_idx[k]];
        end
        if (!hold) begin
            start = 1'b0;
            repeat (4) begin
                @(negedge clock);
                if (plot) extra_plot++;
                if (done) ndone++;
            end
        end
    endtask

    task automatic test_reset();
        int n = 0;
        reset = 1'b1; start = 1'b0; grid = '0; user_x = 8'd0; enemy_x = 8'd0;
        flip_at[0] = -1; flip_at[1] = -1; flip_idx[0] = 0; flip_idx[1] = 0;
        repeat (3) @(negedge clock);
        checks++;
        if ({plot, busy, done, hit} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got plot/busy/done/hit=%b want 0000", {plot, busy, done, hit});
        end else passes++;
        checks++;
        if ({x, y, colour} !== 18'd0) begin
            fails++; $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d want 0/0/0", x, y, colour);
        end else passes++;
        reset = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 1000 && n < 500; c++) begin
            @(negedge clock);
            if (plot) n++;
        end
        checks++;
        if (busy !== 1'b1 || n != 500) begin
            fails++; $display("FAIL mid_frame_busy: got busy=%b plots=%0d want 1/500", busy, n);
        end else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            fails++; $display("FAIL async_reset: got plot/busy/done=%b want 000", {plot, busy, done});
        end else passes++;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({plot, busy, done, hit} !== 4'b0000) begin
            fails++; $display("FAIL post_abort: got plot/busy/done/hit=%b want 0000", {plot, busy, done, hit});
        end else passes++;
    endtask

    task automatic test_empty_grid();
        int greens = 0, bad;
        grid = '0; user_x = 8'd10; enemy_x = 8'd200; mux = 10; mex = 200;
        start = 1'b1;
        capture(-1, -1, 1'b0, -1, 8'd0);
        bad = count_pix_bad();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                if (fb[i][j] === 3'b010) greens++;
        checks++;
        if (nplot != 19200) begin fails++; $display("FAIL empty_count: got %0d want 19200", nplot); end else passes++;
        checks++;
        if (fx != 0 || fy != 0) begin fails++; $display("FAIL first_after_reset: got (%0d,%0d) want (0,0)", fx, fy); end else passes++;
        checks++;
        if (fb[10][0] !== 3'b010 || greens != 1) begin
            fails++; $display("FAIL empty_ship: got c=%0d greens=%0d want 2/1", fb[10][0], greens);
        end else passes++;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL empty_pixels: got %0d bad want 0", bad); end else passes++;
        checks++;
        if (ndone != 1 || cap_hit !== 1'b0 || cap_busy !== 1'b0) begin
            fails++; $display("FAIL empty_done: got done=%0d hit=%b busy=%b want 1/0/0", ndone, cap_hit, cap_busy);
        end else passes++;
        checks++;
        if (order_err != 0 || busy_err != 0) begin
            fails++; $display("FAIL empty_order: got order_err=%0d busy_err=%0d want 0/0", order_err, busy_err);
        end else passes++;
    endtask

    task automatic test_single_bullet_busy();
        int bad;
        grid = '0; grid[120*5 + 40] = 1'b1;
        user_x = 8'd0; enemy_x = 8'd159; mux = 0; mex = 159;
        start = 1'b1;
        capture(100, 5000, 1'b0, -1, 8'd0);
        bad = count_pix_bad();
        checks++;
        if (fb[5][40] !== 3'b111 || fb[0][0] !== 3'b010 || fb[159][119] !== 3'b100) begin
            fails++; $display("FAIL single_sprites: got %0d/%0d/%0d want 7/2/4", fb[5][40], fb[0][0], fb[159][119]);
        end else passes++;
        checks++;
        if (fx != 0 || fy != 0 || lx != 159 || ly != 119) begin
            fails++; $display("FAIL single_ends: got (%0d,%0d)..(%0d,%0d) want (0,0)..(159,119)", fx, fy, lx, ly);
        end else passes++;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL single_pixels: got %0d bad want 0", bad); end else passes++;
        checks++;
        if (nplot != 19200 || ndone != 1 || extra_plot != 0) begin
            fails++; $display("FAIL start_busy: got plots=%0d dones=%0d extra=%0d want 19200/1/0", nplot, ndone, extra_plot);
        end else passes++;
        checks++;
        if (cap_hit !== exp_hit || cap_hit !== 1'b0) begin
            fails++; $display("FAIL single_hit: got %b want 0", cap_hit);
        end else passes++;
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int i = 0; i < 19200; i++) grid[i] = ($urandom_range(0, 15) == 0);
        grid[120*70 + 119] = 1'b1;
        flip_at[0] = 5000;  flip_idx[0] = 120*150 + 60;
        flip_at[1] = 19000; flip_idx[1] = 120*70 + 119;
        user_x = 8'd3; enemy_x = 8'd70; mux = 3; mex = 70;
        start = 1'b1;
        capture(-1, -1, 1'b1, 5000, 8'd9);
        bad = count_pix_bad();
        checks++;
        if (fb[3][0] !== 3'b010 || fb[70][119] !== 3'b100) begin
            fails++; $display("FAIL b2b_f1_sprites: got ship=%0d enemy=%0d want 2/4", fb[3][0], fb[70][119]);
        end else passes++;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL b2b_f1_pixels: got %0d bad want 0", bad); end else passes++;
        checks++;
        if (cap_hit !== 1'b1 || exp_hit !== 1'b1) begin
            fails++; $display("FAIL hit_detect: got %b want 1", cap_hit);
        end else passes++;
        checks++;
        if (nplot != 19200 || ndone != 1) begin
            fails++; $display("FAIL b2b_f1_count: got plots=%0d dones=%0d want 19200/1", nplot, ndone);
        end else passes++;
        flip_at[0] = -1; flip_at[1] = -1; mux = 9;
        capture(-1, -1, 1'b1, -1, 8'd0);
        start = 1'b0;
        bad = count_pix_bad();
        checks++;
        if (gap != 1) begin fails++; $display("FAIL b2b_gap: got %0d idle cycles want 1", gap); end else passes++;
        checks++;
        if (fb[9][0] !== 3'b010 || bad != 0) begin
            fails++; $display("FAIL b2b_f2_pixels: got ship=%0d bad=%0d want 2/0", fb[9][0], bad);
        end else passes++;
        checks++;
        if (cap_hit !== 1'b0 || exp_hit !== 1'b0) begin
            fails++; $display("FAIL hit_cleared: got %b want 0", cap_hit);
        end else passes++;
        repeat (3) @(negedge clock);
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_stop: got plot=%b busy=%b want 0/0", plot, busy);
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_empty_grid();
        test_single_bullet_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
